// File: rtl/dwt_bank_arbiter.sv
// N-bank frame-buffer arbiter between the DWT engine and the display reader.
// Bank 0 holds the source image; banks 1..N-1 are ping-ponged work banks.
module dwt_bank_arbiter #(
  parameter int unsigned NUM_BANKS    = 3,
  parameter int unsigned ADDR_BW      = 18,
  parameter int unsigned DATA_BW      = 8,
  parameter int unsigned HOLD_DISPLAY = 0,
  parameter int unsigned CNT_BW       = 4,
  localparam int unsigned BANK_BW     = $clog2(NUM_BANKS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_we,
  input  logic [ADDR_BW-1:0] load_addr,
  input  logic [DATA_BW-1:0] load_data,
  input  logic               start,
  input  logic               pass_done,
  input  logic               frame_done,
  input  logic               dwt_disabled,
  input  logic [ADDR_BW-1:0] dwt_read_addr,
  input  logic [ADDR_BW-1:0] dwt_write_addr,
  input  logic [DATA_BW-1:0] dwt_write_data,
  input  logic               dwt_we,
  input  logic [ADDR_BW-1:0] display_read_addr,
  output logic [DATA_BW-1:0] dwt_read_data,
  output logic [DATA_BW-1:0] display_read_data,
  output logic               busy,
  output logic [BANK_BW-1:0] src_bank,
  output logic [BANK_BW-1:0] dst_bank,
  output logic [BANK_BW-1:0] disp_bank,
  output logic [CNT_BW-1:0]  pass_count,
  output logic               write_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BW;

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [BANK_BW-1:0] src_q, src_d, dst_q, dst_d, disp_q, disp_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [BANK_BW-1:0] dwt_sel, disp_sel, dwt_sel_q, disp_sel_q;
  logic [DATA_BW-1:0] dwt_rd  [NUM_BANKS];
  logic [DATA_BW-1:0] disp_rd [NUM_BANKS];

  // Next work bank after cur, wrapping N-1 -> 1, optionally skipping the displayed bank.
  function automatic logic [BANK_BW-1:0] next_work(input logic [BANK_BW-1:0] cur,
                                                   input logic [BANK_BW-1:0] skip);
    int c;
    c = int'(cur) + 1;
    if (c >= int'(NUM_BANKS)) c = 1;
    if (HOLD_DISPLAY != 0 && c == int'(skip)) begin
      c = c + 1;
      if (c >= int'(NUM_BANKS)) c = 1;
    end
    return BANK_BW'(c);
  endfunction

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (dwt_we) err_d = 1'b1;
        if (start && !dwt_disabled) begin
          state_d = StRun;
          src_d   = '0;
          dst_d   = next_work(BANK_BW'(NUM_BANKS - 1), disp_q);
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (load_we) err_d = 1'b1;
        if (frame_done) begin
          disp_d  = dst_q;
          state_d = StIdle;
        end else if (pass_done) begin
          src_d = dst_q;
          dst_d = next_work(dst_q, disp_q);
          if (cnt_q != {CNT_BW{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dwt_sel = (state_q == StRun) ? src_q : '0;
    if (dwt_disabled) begin
      disp_sel = '0;
    end else if (state_q == StRun) begin
      disp_sel = (HOLD_DISPLAY != 0) ? disp_q : '0;
    end else begin
      disp_sel = disp_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= BANK_BW'(1);
      disp_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      dwt_sel_q  <= '0;
      disp_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      dwt_sel_q  <= dwt_sel;
      disp_sel_q <= disp_sel;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_BW-1:0] mem [DEPTH];
    logic               we;
    logic [ADDR_BW-1:0] waddr;
    logic [DATA_BW-1:0] wdata;
    logic [DATA_BW-1:0] dwt_rd_q, disp_rd_q;

    if (b == 0) begin : g_src
      assign we    = (state_q == StIdle) && load_we;
      assign waddr = load_addr;
      assign wdata = load_data;
    end else begin : g_work
      assign we    = (state_q == StRun) && dwt_we && (dst_q == BANK_BW'(b));
      assign waddr = dwt_write_addr;
      assign wdata = dwt_write_data;
    end

    always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        dwt_rd_q  <= '0;
        disp_rd_q <= '0;
      end else begin
        dwt_rd_q  <= mem[dwt_read_addr];
        disp_rd_q <= mem[display_read_addr];
      end
    end

    assign dwt_rd[b]  = dwt_rd_q;
    assign disp_rd[b] = disp_rd_q;
  end

  // Registered selects keep returned data tied to the bank chosen in the request cycle.
  assign dwt_read_data     = dwt_rd[dwt_sel_q];
  assign display_read_data = disp_rd[disp_sel_q];
  assign busy              = (state_q == StRun);
  assign src_bank          = src_q;
  assign dst_bank          = dst_q;
  assign disp_bank         = disp_q;
  assign pass_count        = cnt_q;
  assign write_err         = err_q;

endmodule

// File: tb/tb_dwt_bank_arbiter.sv
// Bench for dwt_bank_arbiter: a 3-bank and a 4-bank hold-display instance share stimulus
// and are checked every cycle against a bank-level reference model.
module tb_dwt_bank_arbiter;
  localparam int AW = 6;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, load_we, start, pass_done, frame_done, dwt_disabled, dwt_we;
  logic [AW-1:0] load_addr, dwt_read_addr, dwt_write_addr, display_read_addr;
  logic [DW-1:0] load_data, dwt_write_data;

  logic [DW-1:0] drd [2];
  logic [DW-1:0] prd [2];
  logic          bsy [2];
  logic [1:0]    srcb [2];
  logic [1:0]    dstb [2];
  logic [1:0]    dispb [2];
  logic [CW-1:0] pcnt [2];
  logic          werr [2];

  dwt_bank_arbiter #(
    .NUM_BANKS(3), .ADDR_BW(AW), .DATA_BW(DW), .HOLD_DISPLAY(0), .CNT_BW(CW)
  ) u_dut3 (
    .clock(clock), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .pass_done(pass_done), .frame_done(frame_done),
    .dwt_disabled(dwt_disabled), .dwt_read_addr(dwt_read_addr),
    .dwt_write_addr(dwt_write_addr), .dwt_write_data(dwt_write_data), .dwt_we(dwt_we),
    .display_read_addr(display_read_addr), .dwt_read_data(drd[0]),
    .display_read_data(prd[0]), .busy(bsy[0]), .src_bank(srcb[0]), .dst_bank(dstb[0]),
    .disp_bank(dispb[0]), .pass_count(pcnt[0]), .write_err(werr[0])
  );

  dwt_bank_arbiter #(
    .NUM_BANKS(4), .ADDR_BW(AW), .DATA_BW(DW), .HOLD_DISPLAY(1), .CNT_BW(CW)
  ) u_dut4 (
    .clock(clock), .reset(reset), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .start(start), .pass_done(pass_done), .frame_done(frame_done),
    .dwt_disabled(dwt_disabled), .dwt_read_addr(dwt_read_addr),
    .dwt_write_addr(dwt_write_addr), .dwt_write_data(dwt_write_data), .dwt_we(dwt_we),
    .display_read_addr(display_read_addr), .dwt_read_data(drd[1]),
    .display_read_data(prd[1]), .busy(bsy[1]), .src_bank(srcb[1]), .dst_bank(dstb[1]),
    .disp_bank(dispb[1]), .pass_count(pcnt[1]), .write_err(werr[1])
  );

  int nb [2]   = '{3, 4};
  bit hold [2] = '{1'b0, 1'b1};

  bit m_run [2];
  int m_src [2], m_dst [2], m_disp [2], m_cnt [2];
  bit m_err [2];
  int mem [2][4][64];
  bit vld [2][4][64];
  int e_drd [2], e_prd [2];
  bit e_dv [2], e_pv [2];

  int tests = 0;
  int fails = 0;

  // First work bank after cur in ascending wrap order that the display is not holding.
  function automatic int next_work(int k, int cur);
    int c;
    for (int i = 1; i < nb[k]; i++) begin
      c = ((cur - 1 + i) % (nb[k] - 1)) + 1;
      if (!hold[k] || c != m_disp[k]) return c;
    end
    return cur;
  endfunction

  task automatic model_step();
    int dsel, psel, nd;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_run[k] = 1'b0; m_src[k] = 0; m_dst[k] = 1; m_disp[k] = 0; m_cnt[k] = 0;
        m_err[k] = 1'b0;
        e_drd[k] = 0; e_dv[k] = 1'b1; e_prd[k] = 0; e_pv[k] = 1'b1;
      end else begin
        dsel = m_run[k] ? m_src[k] : 0;
        if (dwt_disabled) psel = 0;
        else if (m_run[k]) psel = hold[k] ? m_disp[k] : 0;
        else psel = m_disp[k];
        e_dv[k]  = vld[k][dsel][dwt_read_addr];
        e_drd[k] = mem[k][dsel][dwt_read_addr];
        e_pv[k]  = vld[k][psel][display_read_addr];
        e_prd[k] = mem[k][psel][display_read_addr];
        if (!m_run[k]) begin
          if (load_we) begin
            mem[k][0][load_addr] = int'(load_data);
            vld[k][0][load_addr] = 1'b1;
          end
          if (dwt_we) m_err[k] = 1'b1;
          if (start && !dwt_disabled) begin
            m_run[k] = 1'b1; m_src[k] = 0; m_cnt[k] = 0;
            m_dst[k] = next_work(k, nb[k] - 1);
          end
        end else begin
          if (dwt_we) begin
            mem[k][m_dst[k]][dwt_write_addr] = int'(dwt_write_data);
            vld[k][m_dst[k]][dwt_write_addr] = 1'b1;
          end
          if (load_we) m_err[k] = 1'b1;
          if (frame_done) begin
            m_disp[k] = m_dst[k];
            m_run[k]  = 1'b0;
          end else if (pass_done) begin
            nd = next_work(k, m_dst[k]);
            m_src[k] = m_dst[k];
            m_dst[k] = nd;
            if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
          end
        end
      end
    end
  endtask

  task automatic chk(int k, string tag, logic [31:0] obs, int exp);
    tests++;
    assert (obs === 32'(exp)) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "busy", 32'(bsy[k]), int'(m_run[k]));
      chk(k, "src_bank", 32'(srcb[k]), m_src[k]);
      chk(k, "dst_bank", 32'(dstb[k]), m_dst[k]);
      chk(k, "disp_bank", 32'(dispb[k]), m_disp[k]);
      chk(k, "pass_count", 32'(pcnt[k]), m_cnt[k]);
      chk(k, "write_err", 32'(werr[k]), int'(m_err[k]));
      if (e_dv[k]) chk(k, "dwt_read_data", 32'(drd[k]), e_drd[k]);
      if (e_pv[k]) chk(k, "display_read_data", 32'(prd[k]), e_prd[k]);
    end
    start = 1'b0; pass_done = 1'b0; frame_done = 1'b0; load_we = 1'b0; dwt_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_we = 1'b0; start = 1'b0; pass_done = 1'b0; frame_done = 1'b0;
    dwt_disabled = 1'b0; dwt_we = 1'b0;
    load_addr = '0; dwt_read_addr = '0; dwt_write_addr = '0; display_read_addr = '0;
    load_data = '0; dwt_write_data = '0;
    step(); step();
    reset = 1'b1;

    // Source image: data equals address.
    for (int a = 0; a < 64; a++) begin
      load_we = 1'b1; load_addr = AW'(a); load_data = DW'(a);
      dwt_read_addr = AW'(a); display_read_addr = AW'(63 - a);
      step();
    end
    dwt_read_addr = AW'(5); step();

    // Frame 1: two passes then commit.
    start = 1'b1; step();
    dwt_we = 1'b1; dwt_write_addr = '0; dwt_write_data = 8'hAA; step();
    pass_done = 1'b1; step();
    dwt_we = 1'b1; dwt_write_data = 8'h55; dwt_read_addr = '0; step();
    pass_done = 1'b1; step();
    frame_done = 1'b1; step();
    display_read_addr = '0; step(); step();

    // Frame 2 leaves the 4-bank instance displaying bank 2.
    start = 1'b1; step();
    dwt_we = 1'b1; dwt_write_addr = AW'(1); dwt_write_data = 8'h33; step();
    pass_done = 1'b1; step();
    frame_done = 1'b1; step();

    // Frame 3: work banks must avoid the held display bank.
    start = 1'b1; step();
    for (int p = 0; p < 2; p++) begin
      dwt_we = 1'b1; dwt_write_addr = AW'($urandom_range(1, 63));
      dwt_write_data = DW'($urandom); step();
      pass_done = 1'b1; step();
    end
    frame_done = 1'b1; step();

    // pass_done and frame_done together: frame wins.
    start = 1'b1; step();
    pass_done = 1'b1; step();
    pass_done = 1'b1; frame_done = 1'b1; step();

    // Illegal writes.
    dwt_we = 1'b1; dwt_write_addr = AW'(3); dwt_write_data = 8'hEE; step();
    start = 1'b1; step();
    load_we = 1'b1; load_addr = AW'(3); load_data = 8'hEE; step();
    frame_done = 1'b1; step();
    dwt_read_addr = AW'(3); step(); step();

    // Disabled DWT ignores start and forces display to bank 0.
    dwt_disabled = 1'b1; start = 1'b1; step(); step();
    dwt_disabled = 1'b0;

    // Reset mid-run.
    start = 1'b1; step();
    pass_done = 1'b1; step();
    reset = 1'b0; step();
    reset = 1'b1; start = 1'b1; step(); step();

    // Pass counter saturation.
    for (int p = 0; p < 17; p++) begin
      pass_done = 1'b1; step();
    end
    frame_done = 1'b1; step();

    // Randomized traffic.
    repeat (400) begin
      start          = ($urandom_range(0, 7) == 0);
      pass_done      = ($urandom_range(0, 5) == 0);
      frame_done     = ($urandom_range(0, 11) == 0);
      dwt_we         = ($urandom_range(0, 1) == 0);
      load_we        = ($urandom_range(0, 5) == 0);
      dwt_disabled   = ($urandom_range(0, 9) == 0);
      load_addr      = AW'($urandom); load_data = DW'($urandom);
      dwt_read_addr  = AW'($urandom); dwt_write_addr = AW'($urandom);
      dwt_write_data = DW'($urandom); display_read_addr = AW'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
